// File: rtl/regfile_write_queue.sv
// ============================================================================
// Module   : regfile_write_queue
// Purpose  : In-order write-back queue feeding a 32 x WIDTH register array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] regs [31:0],
  output logic [31:0]      pending,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [4:0]       q_addr  [DEPTH];
  logic [WIDTH-1:0] q_data  [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             retire;
  logic [4:0]       head_addr;
  logic [WIDTH-1:0] head_data;
  logic [31:0]      wr_en;
  logic [WIDTH-1:0] reg_q   [31];

  // Ready comes from the registered count only, so a retire in a full cycle
  // frees the slot one cycle later and no input reaches an output.
  assign wr_ready  = (count < FULL_CNT);
  assign empty     = (count == '0);
  assign accept    = wr_valid && wr_ready;
  assign retire    = !empty;
  assign head_addr = q_addr[head];
  assign head_data = q_data[head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (retire) begin
        q_valid[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (accept) begin
        q_addr[tail]  <= wr_addr;
        q_data[tail]  <= wr_data;
        q_valid[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      case ({accept, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // One-hot write decode; register 31 is hard-wired zero and never enabled.
  always_comb begin
    wr_en = '0;
    if (retire) begin
      wr_en = 32'd1 << head_addr;
    end
    wr_en[31] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 31; r++) begin
        reg_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 31; r++) begin
        if (wr_en[r]) begin
          reg_q[r] <= head_data;
        end
      end
    end
  end

  for (genvar g = 0; g < 31; g++) begin : g_regs_out
    assign regs[g] = reg_q[g];
  end
  assign regs[31] = '0;

  always_comb begin
    pending = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (q_valid[e]) begin
        pending[q_addr[e]] = 1'b1;
      end
    end
    pending[31] = 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
// ============================================================================
// Module   : tb_regfile_write_queue
// Purpose  : Directed vector table plus reference-model scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_queue;

  localparam int WIDTH = 64;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] regs [31:0];
  logic [31:0]      pending;
  logic             empty;

  regfile_write_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .regs     (regs),
    .pending  (pending),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [63:0] d;
    logic [31:0] ep;
    logic        ee;
    logic [4:0]  ca;
    logic [63:0] cd;
  } vec_t;

  vec_t        vecs [9];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_regs [32];
  bit          have_prev;
  logic [4:0]  prev_addr;
  logic [63:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    have_prev = 1'b0;
    prev_addr = '0;
    prev_data = '0;
  endtask

  // Drive one request, take one edge, update the model (1-cycle latency).
  task automatic cycle(input logic v, input logic [4:0] a, input logic [63:0] d);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    @(posedge clk);
    if (have_prev && prev_addr != 5'd31) exp_regs[prev_addr] = prev_data;
    have_prev = v;
    prev_addr = a;
    prev_data = d;
    #1;
  endtask

  task automatic check_model_state(input string tag);
    logic [31:0] ep;
    ep = '0;
    if (have_prev && prev_addr != 5'd31) ep = 32'd1 << prev_addr;
    chk({tag, "_pending"}, {32'd0, pending}, {32'd0, ep});
    chk({tag, "_empty"}, {63'd0, empty}, {63'd0, !have_prev});
    chk({tag, "_ready"}, {63'd0, wr_ready}, 64'd1);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_reg%0d", tag, i), regs[i], exp_regs[i]);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, 32'h0000_0020, 1'b0, 5'd5,  64'h0};
    vecs[1] = '{1'b0, 5'd0,  64'h0,                 32'h0000_0000, 1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D};
    vecs[2] = '{1'b1, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 32'h0000_0000, 1'b0, 5'd31, 64'h0};
    vecs[3] = '{1'b0, 5'd0,  64'h0,                 32'h0000_0000, 1'b1, 5'd31, 64'h0};
    vecs[4] = '{1'b1, 5'd3,  64'h11,                32'h0000_0008, 1'b0, 5'd3,  64'h0};
    vecs[5] = '{1'b1, 5'd3,  64'h22,                32'h0000_0008, 1'b0, 5'd3,  64'h11};
    vecs[6] = '{1'b1, 5'd7,  64'h33,                32'h0000_0080, 1'b0, 5'd3,  64'h22};
    vecs[7] = '{1'b0, 5'd0,  64'h0,                 32'h0000_0000, 1'b1, 5'd7,  64'h33};
    vecs[8] = '{1'b0, 5'd0,  64'h0,                 32'h0000_0000, 1'b1, 5'd3,  64'h22};

    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_ready", {63'd0, wr_ready}, 64'd1);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_pending", {32'd0, pending}, 64'd0);
    check_regs("rst");

    // Directed table: single write, zero register, same-address ordering.
    for (int k = 0; k < 9; k++) begin
      cycle(vecs[k].v, vecs[k].a, vecs[k].d);
      chk($sformatf("vec%0d_pending", k), {32'd0, pending}, {32'd0, vecs[k].ep});
      chk($sformatf("vec%0d_empty", k), {63'd0, empty}, {63'd0, vecs[k].ee});
      chk($sformatf("vec%0d_ready", k), {63'd0, wr_ready}, 64'd1);
      chk($sformatf("vec%0d_reg%0d", k, vecs[k].ca), regs[vecs[k].ca], vecs[k].cd);
    end
    check_regs("table_end");

    // Back-to-back: one write per cycle, occupancy held at 1.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101);
      chk($sformatf("b2b%0d_ready", i), {63'd0, wr_ready}, 64'd1);
      chk($sformatf("b2b%0d_empty", i), {63'd0, empty}, 64'd0);
      chk($sformatf("b2b%0d_pend31", i), {63'd0, pending[31]}, 64'd0);
      chk($sformatf("b2b%0d_pending", i), {32'd0, pending},
          (i == 31) ? 64'd0 : (64'd1 << i));
    end
    cycle(1'b0, 5'd0, 64'd0);
    chk("b2b_drain_empty", {63'd0, empty}, 64'd1);
    for (int i = 0; i < 32; i++)
      chk($sformatf("b2b_final_reg%0d", i), regs[i],
          (i == 31) ? 64'd0 : 64'(i) * 64'h0101_0101_0101_0101);

    // Reset asserted mid-queue clears state without waiting for a clock.
    cycle(1'b1, 5'd9, 64'h99);
    chk("midq_pending", {32'd0, pending}, 64'h200);
    wr_valid = 1'b0;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk("midq_rst_empty", {63'd0, empty}, 64'd1);
    chk("midq_rst_pending", {32'd0, pending}, 64'd0);
    chk("midq_rst_ready", {63'd0, wr_ready}, 64'd1);
    check_regs("midq_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b0, 5'd0, 64'd0);
    check_regs("midq_after");
    check_model_state("midq_after");

    // Scoreboard: random mix of idle, isolated and back-to-back writes.
    for (int n = 0; n < 300; n++) begin
      logic        v;
      logic [4:0]  a;
      logic [63:0] d;
      v = ($urandom_range(0, 3) != 0);
      a = 5'($urandom_range(0, 31));
      d = {$urandom, $urandom};
      cycle(v, a, d);
      check_model_state($sformatf("sb%0d", n));
      check_regs($sformatf("sb%0d", n));
    end
    cycle(1'b0, 5'd0, 64'd0);
    cycle(1'b0, 5'd0, 64'd0);
    check_model_state("sb_drain");
    check_regs("sb_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
